fifo_control: RTL and testbench
===============================

FIFO_CONTROL -- requirements
Module: fifo_control

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of data words in the attached memory; no data path passes through this block.
REQ-002 Parameter ADDR_WIDTH, default 3: memory address width; DEPTH = 2^ADDR_WIDTH words.
REQ-003 Parameter ALMOST_FULL, default 6: count threshold for almost_full.
REQ-004 Parameter ALMOST_EMPTY, default 2: count threshold for almost_empty.
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-007 Port reset_L, input, 1: synchronous active-low reset.
REQ-008 Port push, input, 1: write request.
REQ-009 Port pop, input, 1: read request.
REQ-010 Port wr_ptr, output, ADDR_WIDTH: memory write address.
REQ-011 Port rd_ptr, output, ADDR_WIDTH: memory read address.
REQ-012 Port write_enable, output, 1: memory write strobe.
REQ-013 Port read_enable, output, 1: memory read strobe.
REQ-014 Port full / empty / almost_full / almost_empty, output, 1 each: occupancy flags.
REQ-015 Port fifo_count, output, ADDR_WIDTH+1: stored word count, 0..DEPTH.
REQ-016 Port data_valid, output, 1: memory FIFO_data_out holds a popped word this cycle.
REQ-017 Port overflow_err / underflow_err, output, 1 each: sticky error flags.

Function
REQ-018 FSM states INIT, IDLE, ACTIVE, ERROR; INIT lasts exactly one cycle after reset release, then IDLE.
REQ-019 In INIT, push and pop shall be ignored; write_enable, read_enable shall be 0; no error flags set.
REQ-020 IDLE when fifo_count==0, ACTIVE when fifo_count>0; transitions follow registered count each cycle.
REQ-021 Any rejected request (REQ-024/025) shall move FSM to ERROR; ERROR is left only by reset; push/pop keep being serviced normally in ERROR.
REQ-022 write_enable = push & !full & state!=INIT, combinational; wr_ptr is current registered write pointer.
REQ-023 read_enable = pop & !empty & state!=INIT, combinational; rd_ptr is current registered read pointer.
REQ-024 Push while full: rejected, no pointer/count change, overflow_err set to 1 next cycle.
REQ-025 Pop while empty: rejected, underflow_err set to 1 next cycle; push in same cycle still accepted (no bypass).
REQ-026 Push and pop both accepted same cycle: both pointers advance, fifo_count unchanged.
REQ-027 Push and pop while full: pop accepted, push rejected with overflow_err.
REQ-028 Pointers increment by 1 per accepted operation, wrapping DEPTH-1 -> 0.
REQ-029 Flags from registered fifo_count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=ALMOST_FULL), almost_empty = (count<=ALMOST_EMPTY).
REQ-030 data_valid shall be 1 exactly the cycle after an accepted pop (memory read latency one cycle), else 0.

Reset
REQ-031 reset_L==0 at a rising edge: wr_ptr=0, rd_ptr=0, fifo_count=0, data_valid=0, overflow_err=0, underflow_err=0, state=INIT; stored data discarded logically.
REQ-032 While reset_L==0, write_enable and read_enable shall be 0 regardless of push/pop.
REQ-033 Reset mid-operation overrides all simultaneous pushes/pops in that cycle.

Structure
REQ-034 Package fifo_pkg shall hold FSM state encoding typedef and DEPTH derivation constant.
REQ-035 Sub-module fifo_ptr_counter (enable, wrap-around ADDR_WIDTH counter, sync active-low reset) shall be instantiated for wr_ptr and rd_ptr.

Verification (ADDR_WIDTH=3, ALMOST_FULL=6, ALMOST_EMPTY=2)
REQ-036 Reset then 8 pushes -> write_enable on each, wr_ptr 0..7 then 0, count 8, full=1, almost_full from count 6.
REQ-037 9th push when full -> write_enable=0, count stays 8, overflow_err=1 next cycle, FSM ERROR.
REQ-038 From empty, pop -> read_enable=0, underflow_err=1; push+pop same cycle from empty -> count 1, only write accepted.
REQ-039 Count 4, push+pop 10 consecutive cycles -> count stays 4, both pointers wrap past 7, data_valid=1 each cycle after first.
REQ-040 Count 5, reset_L=0 one cycle with push=1 -> all outputs at reset values, write_enable=0, one INIT cycle ignores push, then normal.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller: FSM state encoding and
// the depth derivation used by every block that sizes against ADDR_WIDTH.
package fifo_pkg;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_ERROR  = 2'd3
   } fifo_state_t;

   function automatic int depth_of(input int addr_width);
      return 1 << addr_width;
   endfunction

   localparam int DEFAULT_ADDR_WIDTH = 3;
   localparam int DEFAULT_DEPTH      = depth_of(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/fifo_ptr_counter.sv
// Wrap-around address counter with enable; wraps naturally at 2^WIDTH.
module fifo_ptr_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/fifo_control.sv
// FIFO controller: pointers, occupancy count, flags and sticky error flags
// for an external memory; no data passes through this block.
module fifo_control
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 3,
   parameter int ALMOST_FULL  = 6,
   parameter int ALMOST_EMPTY = 2
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  push,
   input  logic                  pop,
   output logic [ADDR_WIDTH-1:0] wr_ptr,
   output logic [ADDR_WIDTH-1:0] rd_ptr,
   output logic                  write_enable,
   output logic                  read_enable,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   fifo_count,
   output logic                  data_valid,
   output logic                  overflow_err,
   output logic                  underflow_err
);

   localparam int DEPTH = depth_of(ADDR_WIDTH);
   localparam int CW    = ADDR_WIDTH + 1;

   if (DATA_WIDTH < 1 || ALMOST_FULL > DEPTH || ALMOST_EMPTY > DEPTH) begin : g_param_check
      $error("fifo_control: inconsistent parameters");
   end

   fifo_state_t     state_reg;
   logic [CW-1:0]   count_reg;
   logic [CW-1:0]   count_next;
   logic            data_valid_reg;
   logic            overflow_reg;
   logic            underflow_reg;
   logic            live;
   logic            push_ok;
   logic            pop_ok;
   logic            push_rej;
   logic            pop_rej;
   logic [1:0]      ptr_en;
   logic [ADDR_WIDTH-1:0] ptr_val [2];

   // Requests only count once reset is released and the INIT cycle has passed.
   assign live     = reset_L && (state_reg != ST_INIT);
   assign full     = (count_reg == CW'(DEPTH));
   assign empty    = (count_reg == '0);
   assign almost_full  = (count_reg >= CW'(ALMOST_FULL));
   assign almost_empty = (count_reg <= CW'(ALMOST_EMPTY));

   assign push_ok  = live && push && !full;
   assign pop_ok   = live && pop && !empty;
   assign push_rej = live && push && full;
   assign pop_rej  = live && pop && empty;

   always_comb begin
      count_next = count_reg;
      if (push_ok && !pop_ok) begin
         count_next = count_reg + 1'b1;
      end else if (!push_ok && pop_ok) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_reg      <= ST_INIT;
         count_reg      <= '0;
         data_valid_reg <= 1'b0;
         overflow_reg   <= 1'b0;
         underflow_reg  <= 1'b0;
      end else begin
         count_reg      <= count_next;
         data_valid_reg <= pop_ok;
         if (push_rej) overflow_reg  <= 1'b1;
         if (pop_rej)  underflow_reg <= 1'b1;
         case (state_reg)
            ST_INIT:  state_reg <= ST_IDLE;
            ST_ERROR: state_reg <= ST_ERROR;
            default: begin
               if (push_rej || pop_rej)  state_reg <= ST_ERROR;
               else if (count_next != '0) state_reg <= ST_ACTIVE;
               else                       state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Index 0 drives the write pointer, index 1 the read pointer.
   assign ptr_en = {pop_ok, push_ok};

   for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
      fifo_ptr_counter #(.WIDTH(ADDR_WIDTH)) u_ptr (
         .clk     (clk),
         .reset_L (reset_L),
         .enable  (ptr_en[gi]),
         .count   (ptr_val[gi])
      );
   end

   assign wr_ptr        = ptr_val[0];
   assign rd_ptr        = ptr_val[1];
   assign write_enable  = push_ok;
   assign read_enable   = pop_ok;
   assign fifo_count    = count_reg;
   assign data_valid    = data_valid_reg;
   assign overflow_err  = overflow_reg;
   assign underflow_err = underflow_reg;

endmodule

// File: tb/tb_fifo_control.sv
// Bench for fifo_control: queue-based occupancy model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_control;

   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          reset_L = 1'b0;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          write_enable;
   logic          read_enable;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   fifo_count;
   logic          data_valid;
   logic          overflow_err;
   logic          underflow_err;

   int n_checks = 0;
   int n_errors = 0;

   fifo_control #(
      .DATA_WIDTH   (8),
      .ADDR_WIDTH   (AW),
      .ALMOST_FULL  (AF),
      .ALMOST_EMPTY (AE)
   ) dut (
      .clk           (clk),
      .reset_L       (reset_L),
      .push          (push),
      .pop           (pop),
      .wr_ptr        (wr_ptr),
      .rd_ptr        (rd_ptr),
      .write_enable  (write_enable),
      .read_enable   (read_enable),
      .full          (full),
      .empty         (empty),
      .almost_full   (almost_full),
      .almost_empty  (almost_empty),
      .fifo_count    (fifo_count),
      .data_valid    (data_valid),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   always #5 clk = ~clk;

   // Reference model: the queue holds the addresses of stored words.
   int  mq[$];
   int  m_wr = 0;
   int  m_rd = 0;
   bit  m_init = 1'b1;
   bit  m_ovf = 1'b0;
   bit  m_udf = 1'b0;
   bit  m_dv = 1'b0;
   bit  started = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         started = 1'b1;
         if (!reset_L) begin
            mq.delete();
            m_wr = 0; m_rd = 0;
            m_ovf = 1'b0; m_udf = 1'b0; m_dv = 1'b0;
            m_init = 1'b1;
         end else if (m_init) begin
            m_init = 1'b0;
            m_dv = 1'b0;
         end else begin
            bit acc_w, acc_r;
            acc_w = push && (mq.size() < DEPTH);
            acc_r = pop && (mq.size() > 0);
            if (push && !acc_w) m_ovf = 1'b1;
            if (pop && !acc_r)  m_udf = 1'b1;
            m_dv = acc_r;
            if (acc_r) begin
               void'(mq.pop_front());
               m_rd = (m_rd + 1) % DEPTH;
            end
            if (acc_w) begin
               mq.push_back(m_wr);
               m_wr = (m_wr + 1) % DEPTH;
            end
         end
      end
   end

   // Single compare process, sampled mid-cycle.
   always @(negedge clk) begin
      if (started) begin
         int c;
         bit live;
         c = mq.size();
         live = reset_L && !m_init;
         chk("write_enable", int'(write_enable), int'(live && push && c < DEPTH));
         chk("read_enable",  int'(read_enable),  int'(live && pop && c > 0));
         chk("fifo_count",   int'(fifo_count),   c);
         chk("wr_ptr",       int'(wr_ptr),       m_wr);
         chk("rd_ptr",       int'(rd_ptr),       m_rd);
         chk("full",         int'(full),         int'(c == DEPTH));
         chk("empty",        int'(empty),        int'(c == 0));
         chk("almost_full",  int'(almost_full),  int'(c >= AF));
         chk("almost_empty", int'(almost_empty), int'(c <= AE));
         chk("data_valid",   int'(data_valid),   int'(m_dv));
         chk("overflow_err", int'(overflow_err), int'(m_ovf));
         chk("underflow_err",int'(underflow_err),int'(m_udf));
         if (c > 0) chk("rd_ptr_head", int'(rd_ptr), mq[0]);
      end
   end

   task automatic drive(input bit p, input bit q, input bit rl);
      push = p; pop = q; reset_L = rl;
      @(posedge clk);
      #1;
      $display("cycle t=%0t push=%0b pop=%0b rst_n=%0b -> count=%0d wr=%0d rd=%0d dv=%0b ovf=%0b udf=%0b",
               $time, p, q, rl, fifo_count, wr_ptr, rd_ptr, data_valid, overflow_err, underflow_err);
   endtask

   initial begin
      drive(0, 0, 0);
      drive(0, 0, 0);
      chk("lit_reset_count", int'(fifo_count), 0);
      chk("lit_reset_empty", int'(empty), 1);
      // INIT cycle: both requests ignored, no underflow.
      drive(1, 1, 1);
      chk("lit_init_count", int'(fifo_count), 0);
      chk("lit_init_udf", int'(underflow_err), 0);
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 1);
         if (i == 5) chk("lit_af_at6", int'(almost_full), 1);
         if (i == 4) chk("lit_af_at5", int'(almost_full), 0);
      end
      chk("lit_full_count", int'(fifo_count), 8);
      chk("lit_full_flag", int'(full), 1);
      chk("lit_wr_wrap", int'(wr_ptr), 0);
      drive(1, 0, 1);
      chk("lit_ovf_count", int'(fifo_count), 8);
      chk("lit_ovf_flag", int'(overflow_err), 1);
      for (int i = 0; i < 8; i++) drive(0, 1, 1);
      chk("lit_drained", int'(fifo_count), 0);
      drive(0, 1, 1);
      chk("lit_udf_flag", int'(underflow_err), 1);
      chk("lit_udf_dv", int'(data_valid), 0);
      drive(1, 1, 1);
      chk("lit_pp_empty_count", int'(fifo_count), 1);
      for (int i = 0; i < 3; i++) drive(1, 0, 1);
      chk("lit_count4", int'(fifo_count), 4);
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 1);
         chk("lit_pp_count", int'(fifo_count), 4);
         chk("lit_pp_dv", int'(data_valid), 1);
      end
      chk("lit_pp_wr", int'(wr_ptr), 6);
      chk("lit_pp_rd", int'(rd_ptr), 2);
      drive(1, 0, 1);
      chk("lit_count5", int'(fifo_count), 5);
      drive(1, 0, 0);
      chk("lit_rst_count", int'(fifo_count), 0);
      chk("lit_rst_ovf", int'(overflow_err), 0);
      chk("lit_rst_wr", int'(wr_ptr), 0);
      drive(1, 0, 1);
      chk("lit_rst_init_ignored", int'(fifo_count), 0);
      drive(1, 0, 1);
      chk("lit_rst_resume", int'(fifo_count), 1);

      // Randomized traffic with fill/drain biased phases and rare resets.
      for (int i = 0; i < 800; i++) begin
         int bias;
         bias = ((i / 60) % 2 == 0) ? 80 : 20;
         drive($urandom_range(0, 99) < bias,
               $urandom_range(0, 99) < (100 - bias),
               $urandom_range(0, 59) != 0);
      end
      drive(0, 0, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
